// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler: buffers one-hot key masks in a small FIFO and issues them
// to a consumer one at a time, with a fixed idle gap after each accepted command.
module key_cmd_scheduler #(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] bit_mask,
   input  logic       bit_mask_ready,
   output logic [4:0] cmd,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   input  logic       clr_overflow,
   output logic       overflow,
   output logic [2:0] count
);

   localparam int         PW       = $clog2(DEPTH);
   localparam logic [2:0] FULL_CNT = 3'(DEPTH);
   localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_t;

   state_t          r_state;
   logic [4:0]      r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [2:0]      r_count;
   logic [7:0]      r_gap;
   logic [4:0]      r_cmd;
   logic            r_cmd_valid;
   logic            r_overflow;

   logic            w_push_req;
   logic            w_pop;
   logic            w_full;
   logic            w_push;
   logic            w_drop;

   // A zero mask is not a keypress; a pop frees the slot a same-cycle push needs
   assign w_push_req = bit_mask_ready && (bit_mask != 5'b00000);
   assign w_pop      = r_cmd_valid && cmd_ready;
   assign w_full     = (r_count == FULL_CNT);
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   // FIFO storage: written only on accepted pushes, no reset needed for data
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bit_mask;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 3'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + 3'(w_push) - 3'(w_pop);
      end
   end

   // Sticky overflow: a dropped keypress wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   // Issue FSM: present the head, wait for handshake, then enforce the idle gap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_gap       <= 8'd0;
         r_cmd       <= 5'b00000;
         r_cmd_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_count != 3'd0) begin
                  r_state     <= PRESENT;
                  r_cmd       <= r_mem[r_rd_ptr];
                  r_cmd_valid <= 1'b1;
               end
            end
            PRESENT: begin
               if (cmd_ready) begin
                  r_state     <= GAP;
                  r_gap       <= GAP_LOAD;
                  r_cmd_valid <= 1'b0;
               end
            end
            GAP: begin
               if (r_gap == 8'd0) begin
                  r_state <= IDLE;
               end else begin
                  r_gap <= r_gap - 8'd1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_cmd_valid <= 1'b0;
            end
         endcase
      end
   end

   assign cmd       = r_cmd;
   assign cmd_valid = r_cmd_valid;
   assign overflow  = r_overflow;
   assign count     = r_count;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed testbench for key_cmd_scheduler (DEPTH=4, GAP_CYCLES=16).
module tb_key_cmd_scheduler;

   logic       clk;
   logic       rst;
   logic [4:0] bit_mask;
   logic       bit_mask_ready;
   logic [4:0] cmd;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       clr_overflow;
   logic       overflow;
   logic [2:0] count;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         t0;
   logic [4:0] hs_cmd [$];
   int         hs_cyc [$];
   logic [4:0] keys [4];
   logic [4:0] exp5 [5];

   key_cmd_scheduler #(.DEPTH(4), .GAP_CYCLES(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .bit_mask       (bit_mask),
      .bit_mask_ready (bit_mask_ready),
      .cmd            (cmd),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .clr_overflow   (clr_overflow),
      .overflow       (overflow),
      .count          (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every handshake (sampled half a cycle before the edge that completes it)
   always @(negedge clk) begin
      if (rst && cmd_valid && cmd_ready) begin
         hs_cmd.push_back(cmd);
         hs_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] m);
      bit_mask       = m;
      bit_mask_ready = 1'b1;
      tick();
      bit_mask       = 5'b00000;
      bit_mask_ready = 1'b0;
   endtask

   function automatic logic [4:0] hs_at(input int i);
      if (i < hs_cmd.size()) return hs_cmd[i];
      return 5'bxxxxx;
   endfunction

   initial begin
      keys[0] = 5'b10000;
      keys[1] = 5'b01000;
      keys[2] = 5'b00100;
      keys[3] = 5'b00010;
      rst            = 1'b1;
      bit_mask       = 5'b00000;
      bit_mask_ready = 1'b0;
      cmd_ready      = 1'b0;
      clr_overflow   = 1'b0;
      #1 rst = 1'b0;
      #2;
      chk("reset_valid", 8'(cmd_valid), 8'd0);
      chk("reset_count", 8'(count), 8'd0);
      chk("reset_ovf", 8'(overflow), 8'd0);
      chk("reset_cmd", 8'(cmd), 8'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Single key: valid two cycles after the push, for exactly one cycle
      cmd_ready = 1'b1;
      push(5'b10000);
      chk("single_count1", 8'(count), 8'd1);
      chk("single_valid0", 8'(cmd_valid), 8'd0);
      tick();
      chk("single_valid1", 8'(cmd_valid), 8'd1);
      chk("single_cmd", 8'(cmd), 8'h10);
      tick();
      chk("single_valid_drop", 8'(cmd_valid), 8'd0);
      chk("single_count0", 8'(count), 8'd0);
      chk("single_cmd_hold", 8'(cmd), 8'h10);
      repeat (20) tick();

      // Ordering and 18-cycle issue rate
      hs_cmd.delete();
      hs_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         bit_mask       = keys[i];
         bit_mask_ready = 1'b1;
         tick();
         if (i == 0) t0 = cyc;
      end
      bit_mask       = 5'b00000;
      bit_mask_ready = 1'b0;
      repeat (80) tick();
      chk("order_n", 8'(hs_cmd.size()), 8'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("order_cmd%0d", i), 8'(hs_at(i)), 8'(keys[i]));
      if (hs_cyc.size() == 4) begin
         chk("order_first_lat", 8'(hs_cyc[0] - t0), 8'd1);
         for (int i = 0; i < 3; i++) chk($sformatf("rate%0d", i), 8'(hs_cyc[i+1] - hs_cyc[i]), 8'd18);
      end
      chk("order_count0", 8'(count), 8'd0);

      // Zero mask ignored, backpressure holds cmd
      cmd_ready = 1'b0;
      push(5'b00100);
      chk("bp_count1", 8'(count), 8'd1);
      push(5'b00000);
      chk("zero_mask_count", 8'(count), 8'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("bp_valid%0d", i), 8'(cmd_valid), 8'd1);
         chk($sformatf("bp_cmd%0d", i), 8'(cmd), 8'h04);
      end
      chk("zero_mask_ovf", 8'(overflow), 8'd0);
      cmd_ready = 1'b1;
      tick();
      chk("bp_release_valid", 8'(cmd_valid), 8'd0);
      chk("bp_release_count", 8'(count), 8'd0);
      repeat (20) tick();

      // Overflow: six pushes into a stalled FIFO
      cmd_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push(5'b00001);
         if (i == 3) chk("ovf_before_full", 8'(overflow), 8'd0);
      end
      chk("ovf_count", 8'(count), 8'd4);
      chk("ovf_set", 8'(overflow), 8'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("ovf_clear", 8'(overflow), 8'd0);
      clr_overflow = 1'b1;
      push(5'b00001);
      clr_overflow = 1'b0;
      chk("ovf_set_wins", 8'(overflow), 8'd1);
      chk("ovf_count_kept", 8'(count), 8'd4);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("ovf_clear2", 8'(overflow), 8'd0);
      hs_cmd.delete();
      hs_cyc.delete();
      cmd_ready = 1'b1;
      repeat (90) tick();
      chk("ovf_drain_n", 8'(hs_cmd.size()), 8'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("ovf_drain%0d", i), 8'(hs_at(i)), 8'h01);
      chk("ovf_drain_count", 8'(count), 8'd0);

      // Full FIFO with push on the handshake cycle
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(keys[i]);
      chk("fullpp_count_pre", 8'(count), 8'd4);
      chk("fullpp_valid_pre", 8'(cmd_valid), 8'd1);
      chk("fullpp_cmd_pre", 8'(cmd), 8'h10);
      hs_cmd.delete();
      hs_cyc.delete();
      cmd_ready = 1'b1;
      push(5'b00010);
      chk("fullpp_count", 8'(count), 8'd4);
      chk("fullpp_ovf", 8'(overflow), 8'd0);
      chk("fullpp_valid", 8'(cmd_valid), 8'd0);
      repeat (100) tick();
      exp5[0] = 5'b10000;
      exp5[1] = 5'b01000;
      exp5[2] = 5'b00100;
      exp5[3] = 5'b00010;
      exp5[4] = 5'b00010;
      chk("fullpp_n", 8'(hs_cmd.size()), 8'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("fullpp_cmd%0d", i), 8'(hs_at(i)), 8'(exp5[i]));
      chk("fullpp_count_end", 8'(count), 8'd0);

      // Reset during PRESENT with three queued
      cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(keys[i]);
      chk("rst_pre_valid", 8'(cmd_valid), 8'd1);
      chk("rst_pre_count", 8'(count), 8'd3);
      cmd_ready = 1'b1;
      rst       = 1'b0;
      #1;
      chk("rst_async_valid", 8'(cmd_valid), 8'd0);
      chk("rst_async_count", 8'(count), 8'd0);
      chk("rst_async_cmd", 8'(cmd), 8'd0);
      hs_cmd.delete();
      hs_cyc.delete();
      tick();
      tick();
      rst = 1'b1;
      repeat (30) tick();
      chk("rst_no_issue", 8'(hs_cmd.size()), 8'd0);
      chk("rst_idle_valid", 8'(cmd_valid), 8'd0);
      chk("rst_idle_count", 8'(count), 8'd0);
      push(5'b00010);
      chk("rst_new_count", 8'(count), 8'd1);
      tick();
      chk("rst_new_valid", 8'(cmd_valid), 8'd1);
      chk("rst_new_cmd", 8'(cmd), 8'h02);
      repeat (3) tick();
      chk("rst_new_n", 8'(hs_cmd.size()), 8'd1);
      chk("rst_new_hs", 8'(hs_at(0)), 8'h02);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
